// File: rtl/pool_stream_engine.sv
// rtl/pool_stream_engine.sv - streaming 2x2/4x4 max/average pooling engine with internal row buffer
module pool_stream_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WIDTH  = 64,
    parameter int MAX_HEIGHT = 64
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start,
    input  logic                               cfg_mode,
    input  logic                               cfg_win,
    input  logic [$clog2(MAX_WIDTH + 1)-1:0]   cfg_width,
    input  logic [$clog2(MAX_HEIGHT + 1)-1:0]  cfg_height,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               busy,
    output logic                               done
);

    localparam int WW    = $clog2(MAX_WIDTH + 1);
    localparam int HW    = $clog2(MAX_HEIGHT + 1);
    localparam int ACC_W = DATA_WIDTH + 4;
    localparam int NBUF  = MAX_WIDTH / 2;
    localparam int GW    = $clog2(NBUF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                    mode_q;
    logic                    win_q;
    logic [WW-1:0]           width_q;
    logic [HW-1:0]           height_q;
    logic [WW-1:0]           col;
    logic [HW-1:0]           row;
    logic signed [ACC_W-1:0] row_buf [NBUF];

    logic [WW-1:0]           kmask_w;
    logic [HW-1:0]           kmask_h;
    logic [WW-1:0]           kstart_w;
    logic [HW-1:0]           kstart_h;
    logic                    accept;
    logic                    in_region;
    logic                    win_first;
    logic                    win_last;
    logic                    last_pix;
    logic [GW-1:0]           g;
    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] acc_cur;
    logic signed [ACC_W-1:0] acc_upd;
    logic signed [ACC_W-1:0] acc_shift;
    logic [DATA_WIDTH-1:0]   pooled;

    // Window geometry: K-1 masks from the latched window, K itself from the incoming config
    assign kmask_w  = win_q ? WW'(3) : WW'(1);
    assign kmask_h  = win_q ? HW'(3) : HW'(1);
    assign kstart_w = cfg_win ? WW'(4) : WW'(2);
    assign kstart_h = cfg_win ? HW'(4) : HW'(2);

    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign busy     = (state == S_RUN) || (state == S_FLUSH);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && in_ready;

    // Pixels right of WE or below HE belong to no complete window and are dropped
    assign in_region = (col < (width_q & ~kmask_w)) && (row < (height_q & ~kmask_h));
    assign win_first = ((col & kmask_w) == '0) && ((row & kmask_h) == '0);
    assign win_last  = ((col & kmask_w) == kmask_w) && ((row & kmask_h) == kmask_h);
    assign last_pix  = (col == width_q - 1'b1) && (row == height_q - 1'b1);

    assign g       = win_q ? GW'(col >> 2) : GW'(col >> 1);
    assign pix_ext = {{(ACC_W - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
    assign acc_cur = row_buf[g];

    // Fold the current pixel into its window's partial result
    always_comb begin
        acc_upd = pix_ext;
        if (!win_first) begin
            if (mode_q)
                acc_upd = acc_cur + pix_ext;
            else
                acc_upd = (pix_ext > acc_cur) ? pix_ext : acc_cur;
        end
    end

    // Average divides by K*K with an arithmetic shift so negative sums floor toward -inf
    assign acc_shift = win_q ? (acc_upd >>> 4) : (acc_upd >>> 2);
    assign pooled    = mode_q ? DATA_WIDTH'(acc_shift) : DATA_WIDTH'(acc_upd);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; maps smaller than one window finish without running
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_width < kstart_w) || (cfg_height < kstart_h))
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_pix)
                    state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (!out_valid || out_ready)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Config latch, raster counters, row buffer and output register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_q    <= 1'b0;
            win_q     <= 1'b0;
            width_q   <= '0;
            height_q  <= '0;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NBUF; i++)
                row_buf[i] <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                mode_q   <= cfg_mode;
                win_q    <= cfg_win;
                width_q  <= cfg_width;
                height_q <= cfg_height;
                col      <= '0;
                row      <= '0;
            end
            if (accept) begin
                if (col == width_q - 1'b1) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (in_region)
                    row_buf[g] <= acc_upd;
            end
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && in_region && win_last) begin
                out_valid <= 1'b1;
                out_data  <= pooled;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream_engine.sv
// tb/tb_pool_stream_engine.sv - directed self-checking bench for pool_stream_engine
module tb_pool_stream_engine;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        cfg_mode;
    logic        cfg_win;
    logic [6:0]  cfg_width;
    logic [6:0]  cfg_height;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int pix[$];
    int exp_q[$];

    pool_stream_engine #(
        .DATA_WIDTH (16),
        .MAX_WIDTH  (64),
        .MAX_HEIGHT (64)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .cfg_mode   (cfg_mode),
        .cfg_win    (cfg_win),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic set_ramp(input int n);
        pix.delete();
        for (int i = 0; i < n; i++)
            pix.push_back(i);
    endtask

    task automatic run_map(input string name, input logic mode, input logic win,
                           input int w, input int h, input bit stall, input bit hold);
        int got[$];
        int idx;
        int dones;
        int done_cyc;
        int held;
        int nexp;
        idx      = 0;
        dones    = 0;
        done_cyc = -1;
        held     = 0;
        @(negedge clk);
        cfg_mode   = mode;
        cfg_win    = win;
        cfg_width  = 7'(w);
        cfg_height = 7'(h);
        start      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            in_valid  = (idx < pix.size()) && (!stall || ($urandom_range(0, 2) != 0));
            in_data   = (idx < pix.size()) ? 16'(pix[idx]) : 16'd0;
            out_ready = (hold && held < 5) ? 1'b0 : (!stall || ($urandom_range(0, 2) != 0));
            #1;
            if (hold && out_valid && held < 5) begin
                check({name, " hold in_ready"}, int'(in_ready), 0);
                check({name, " hold out_data"}, int'($signed(out_data)), exp_q[0]);
                check({name, " hold busy"}, int'(busy), 1);
                held++;
            end
            if (in_valid && in_ready)
                idx++;
            if (out_valid && out_ready)
                got.push_back(int'($signed(out_data)));
            if (done) begin
                dones++;
                if (done_cyc < 0)
                    done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3)
                break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nexp = exp_q.size();
        check({name, " output count"}, got.size(), nexp);
        for (int i = 0; i < nexp && i < got.size(); i++)
            check($sformatf("%s out[%0d]", name, i), got[i], exp_q[i]);
        check({name, " done pulses"}, dones, 1);
        if (w < (win ? 4 : 2) || h < (win ? 4 : 2))
            check({name, " done latency ok"}, int'(done_cyc >= 0 && done_cyc <= 1), 1);
    endtask

    initial begin
        int acc;
        nrst       = 1'b0;
        start      = 1'b0;
        cfg_mode   = 1'b0;
        cfg_win    = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        @(negedge clk);
        nrst = 1'b1;

        set_ramp(16);
        exp_q = '{5, 7, 13, 15};
        run_map("max2 4x4", 1'b0, 1'b0, 4, 4, 1'b0, 1'b0);

        exp_q = '{2, 4, 10, 12};
        run_map("avg2 4x4", 1'b1, 1'b0, 4, 4, 1'b0, 1'b0);

        exp_q = '{7};
        run_map("avg4 4x4", 1'b1, 1'b1, 4, 4, 1'b0, 1'b0);

        exp_q = '{15};
        run_map("max4 4x4", 1'b0, 1'b1, 4, 4, 1'b0, 1'b0);

        pix   = '{-1, -2, -3, -4};
        exp_q = '{-3};
        run_map("avg2 neg", 1'b1, 1'b0, 2, 2, 1'b0, 1'b0);

        pix   = '{-8, -3, -5, -7};
        exp_q = '{-3};
        run_map("max2 neg", 1'b0, 1'b0, 2, 2, 1'b0, 1'b0);

        set_ramp(15);
        exp_q = '{6, 8};
        run_map("max2 ragged", 1'b0, 1'b0, 5, 3, 1'b0, 1'b0);

        pix.delete();
        exp_q.delete();
        run_map("zero map", 1'b0, 1'b0, 0, 4, 1'b0, 1'b0);

        set_ramp(16);
        exp_q = '{5, 7, 13, 15};
        run_map("max2 hold", 1'b0, 1'b0, 4, 4, 1'b0, 1'b1);

        exp_q = '{2, 4, 10, 12};
        run_map("avg2 stall", 1'b1, 1'b0, 4, 4, 1'b1, 1'b0);

        exp_q = '{5, 7, 13, 15};
        run_map("max2 stall", 1'b0, 1'b0, 4, 4, 1'b1, 1'b0);

        // Abort a map part-way with reset, then check a clean restart
        @(negedge clk);
        cfg_mode   = 1'b0;
        cfg_win    = 1'b0;
        cfg_width  = 7'd4;
        cfg_height = 7'd4;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = 0;
        for (int cyc = 0; cyc < 100 && acc < 6; cyc++) begin
            in_valid = 1'b1;
            in_data  = 16'd50;
            #1;
            if (in_ready)
                acc++;
            @(negedge clk);
        end
        check("abort accepted", acc, 6);
        nrst     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort out_valid", int'(out_valid), 0);
        check("abort out_data", int'(out_data), 0);
        check("abort busy", int'(busy), 0);
        check("abort in_ready", int'(in_ready), 0);
        @(negedge clk);
        nrst = 1'b1;

        set_ramp(16);
        exp_q = '{5, 7, 13, 15};
        run_map("max2 restart", 1'b0, 1'b0, 4, 4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_stream_engine.md
Name: pool_stream_engine

Overview:
- Parametrised streaming pooling unit; successor to the fixed 2-input max/avg pooling top.
- Consumes a feature map row-major from the systolic array output and emits a pooled map row-major.
- Window is runtime-selectable 2x2 or 4x4, non-overlapping (stride = window); mode is max or average.
- Partial window results are kept in an internal row buffer, so no external register-file addressing is required.

Parameters:
- DATA_WIDTH, 16, signed pixel width (two's complement).
- MAX_WIDTH, 64, maximum feature-map width in pixels; must be a multiple of 4.
- MAX_HEIGHT, 64, maximum feature-map height in pixels.

Ports:
- clk, input, 1, clock.
- nrst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a map; ignored unless IDLE.
- cfg_mode, input, 1, 0 = max, 1 = average; latched on accepted start.
- cfg_win, input, 1, 0 = 2x2, 1 = 4x4; latched on accepted start.
- cfg_width, input, clog2(MAX_WIDTH+1), map width W; latched.
- cfg_height, input, clog2(MAX_HEIGHT+1), map height H; latched.
- in_valid, input, 1, input pixel valid.
- in_ready, output, 1, engine accepts pixel.
- in_data, input, DATA_WIDTH, input pixel.
- out_valid, output, 1, pooled pixel valid.
- out_ready, input, 1, downstream accepts pooled pixel.
- out_data, output, DATA_WIDTH, pooled pixel.
- busy, output, 1, high in RUN and FLUSH.
- done, output, 1, one-cycle pulse at end of map.

Behaviour:
- Reset (async, nrst=0): FSM=IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0; row/column counters and row buffer cleared.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start, latching cfg_*.
  - IDLE -> DONE on start if W<K or H<K (no outputs produced).
  - RUN -> FLUSH when the last pixel (r=H-1, c=W-1) is accepted.
  - FLUSH -> DONE when out_valid=0, or when the pending output is accepted in that cycle.
  - DONE -> IDLE after 1 cycle, with done=1 in that cycle.
- Window size K = 2 or 4; effective width WE = floor(W/K)*K; effective height HE = floor(H/K)*K.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A pixel transfers when in_valid && in_ready.
  - out_valid holds, with out_data stable, until out_ready=1.
- Counters: col c and row r advance per accepted pixel; c wraps W-1 -> 0 and increments r.
- Ragged edges: pixels with c>=WE or r>=HE are accepted and discarded; no state change, no output.
- Accumulation uses row buffer buf[MAX_WIDTH/2] of ACC_W = DATA_WIDTH+4 bits, index g = c/K.
  - First pixel of a window (r%K==0 && c%K==0): buf[g] <= sign-extended pixel.
  - Otherwise max mode: buf[g] <= signed max(buf[g], pixel).
  - Otherwise avg mode: buf[g] <= buf[g] + sign-extended pixel.
- Consecutive pixels hitting the same g must see the previous update; a registered write with combinational read satisfies this, since one pixel is accepted per cycle.
- Output on the last pixel of a window (r%K==K-1 && c%K==K-1):
  - Result is computed from buf[g] combined with the current pixel.
  - Registered into out_data with out_valid=1 on the next edge, i.e. latency 1 cycle from acceptance.
  - Max mode: out_data = result.
  - Avg mode: out_data = result >>> log2(K*K), arithmetic shift (floor toward -inf), low DATA_WIDTH bits. No overflow is possible, since ACC_W covers 16 samples.
- Simultaneous out_ready and a new window completion in the same cycle: the old output retires and the new result loads, giving full throughput.
- start while busy: ignored. cfg_* changes while busy: ignored.
- Reset mid-map: immediate return to IDLE; any pending output is lost.
- Output count = (WE/K)*(HE/K), row-major.

Test Plan:
- Max 2x2, W=H=4, in_data = 0..15 row-major, out_ready=1 -> outputs 5, 7, 13, 15; done pulses once after the last output.
- Avg 2x2, W=H=4, in_data = 0..15 -> outputs 2, 4, 10, 12 (floor of 2.5, 4.5, 10.5, 12.5). Avg 4x4 on the same data -> single output 7.
- Signed avg 2x2, W=H=2, pixels -1, -2, -3, -4 -> output -3 (floor of -2.5). Max on pixels -8, -3, -5, -7 -> -3.
- Ragged: max 2x2, W=5, H=3, in_data = 0..14 -> outputs 6, 8; column 4 and row 2 are consumed with no output. Zero map W=0 -> done 2 cycles after start, no out_valid.
- Backpressure: out_ready held 0 for 5 cycles while output pending -> in_ready=0, out_data stable. Random in_valid/out_ready gaps -> output sequence identical to the no-stall run.
- Reset mid-map (nrst low after 6 of 16 pixels), then restart -> all outputs 0/idle immediately; subsequent full map produces correct results with no stale buffer contribution.
